// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: FSM state, queue entry and PC width.
package bru_pkg;

    localparam int BRU_PC_W = 32;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bru_state_t;

    typedef struct packed {
        logic [BRU_PC_W-1:0] pc;
        logic                pred_taken;
    } bru_entry_t;

endpackage

// File: rtl/bru_fifo.sv
// Circular buffer of in-flight predicted branches, oldest at the head.
// A clear wins over a same-cycle push or pop and leaves the buffer empty.
module bru_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  bru_entry_t                   push_entry,
    output bru_entry_t                   head,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    bru_entry_t       mem_q [DEPTH];
    bru_entry_t       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign occupancy = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves predicted branches in order, drives predictor update and fetch redirect.
// Optional BRU_STATS_EN adds saturating br_count / mispred_count outputs.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FALLTHRU_OFS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pred_valid,
    input  logic [31:0]                pred_pc,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic [31:0]                res_target,
    output logic                       update_en,
    output logic [31:0]                pc_update,
    output logic                       real_br_taken,
    output logic                       mispredict,
    output logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       err_underflow
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]                br_count,
    output logic [31:0]                mispred_count
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    bru_state_t          state_q, state_d;
    bru_entry_t          head, push_entry;
    logic [OCC_W-1:0]    occ;
    logic                full, push, resolve, mismatch;

    logic                update_en_q, update_en_d;
    logic [BRU_PC_W-1:0] pc_update_q, pc_update_d;
    logic                real_br_taken_q, real_br_taken_d;
    logic                mispredict_q, mispredict_d;
    logic [BRU_PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic                err_underflow_q, err_underflow_d;

    // pred_ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        full       = (occ == OCC_W'(DEPTH));
        pred_ready = !rst && (state_q == RUN) && !full;
        push       = pred_valid && pred_ready;
        resolve    = res_valid && (occ != '0);
        mismatch   = resolve && (res_taken != head.pred_taken);
        push_entry = '{pc: pred_pc, pred_taken: pred_taken};

        state_d = RUN;
        if (state_q == RUN && mismatch) begin
            state_d = RECOVER;
        end

        update_en_d     = resolve;
        pc_update_d     = resolve ? head.pc : pc_update_q;
        real_br_taken_d = resolve ? res_taken : real_br_taken_q;
        mispredict_d    = mismatch;
        redirect_pc_d   = redirect_pc_q;
        if (mismatch) begin
            redirect_pc_d = res_taken ? res_target : head.pc + BRU_PC_W'(FALLTHRU_OFS);
        end
        err_underflow_d = err_underflow_q || (res_valid && (occ == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            update_en_q     <= 1'b0;
            pc_update_q     <= '0;
            real_br_taken_q <= 1'b0;
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            update_en_q     <= update_en_d;
            pc_update_q     <= pc_update_d;
            real_br_taken_q <= real_br_taken_d;
            mispredict_q    <= mispredict_d;
            redirect_pc_q   <= redirect_pc_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // A mispredict clears the whole queue, which also discards a same-cycle push.
    bru_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (resolve),
        .clear      (mismatch),
        .push_entry (push_entry),
        .head       (head),
        .occupancy  (occ)
    );

    assign update_en     = update_en_q;
    assign pc_update     = pc_update_q;
    assign real_br_taken = real_br_taken_q;
    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_pc_q;
    assign occupancy     = occ;
    assign err_underflow = err_underflow_q;

`ifdef BRU_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (resolve && br_count_q != 32'hFFFF_FFFF) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (mismatch && mispred_count_q != 32'hFFFF_FFFF) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios plus random traffic
// checked against a queue-based reference model of in-flight branches.
module tb_branch_resolve_unit;

    localparam int DEPTH        = 4;
    localparam int FALLTHRU_OFS = 4;
    localparam int OCC_W        = $clog2(DEPTH+1);

    logic             clk;
    logic             rst;
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic [31:0]      res_target;
    logic             update_en;
    logic [31:0]      pc_update;
    logic             real_br_taken;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic [OCC_W-1:0] occupancy;
    logic             err_underflow;
`ifdef BRU_STATS_EN
    logic [31:0]      br_count;
    logic [31:0]      mispred_count;
`endif

    branch_resolve_unit #(.DEPTH(DEPTH), .FALLTHRU_OFS(FALLTHRU_OFS)) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid    (pred_valid),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .pred_ready    (pred_ready),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_target    (res_target),
        .update_en     (update_en),
        .pc_update     (pc_update),
        .real_br_taken (real_br_taken),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .occupancy     (occupancy),
        .err_underflow (err_underflow)
`ifdef BRU_STATS_EN
        ,
        .br_count      (br_count),
        .mispred_count (mispred_count)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds {pc, pred_taken} of every branch the model believes is in flight.
    logic [32:0] exp_q[$];
    logic        m_recover;
    logic        m_err;
    logic        m_upd;
    logic        m_mis;
    logic        m_real;
    logic [31:0] m_pcu;
    logic [31:0] m_redir;
    logic [31:0] m_br;
    logic [31:0] m_mp;

    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_recover = 1'b0;
        m_err     = 1'b0;
        m_upd     = 1'b0;
        m_mis     = 1'b0;
        m_real    = 1'b0;
        m_pcu     = '0;
        m_redir   = '0;
        m_br      = '0;
        m_mp      = '0;
    endtask

    task automatic check_outputs();
        check("update_en",     32'(update_en),     32'(m_upd));
        check("mispredict",    32'(mispredict),    32'(m_mis));
        check("real_br_taken", 32'(real_br_taken), 32'(m_real));
        check("pc_update",     pc_update,          m_pcu);
        check("redirect_pc",   redirect_pc,        m_redir);
        check("occupancy",     32'(occupancy),     32'(exp_q.size()));
        check("err_underflow", 32'(err_underflow), 32'(m_err));
`ifdef BRU_STATS_EN
        check("br_count",      br_count,           m_br);
        check("mispred_count", mispred_count,      m_mp);
`endif
    endtask

    // All outputs must read 0 while reset is held.
    task automatic check_reset_outputs();
        check("rst_update_en",     32'(update_en),     32'd0);
        check("rst_mispredict",    32'(mispredict),    32'd0);
        check("rst_real_br_taken", 32'(real_br_taken), 32'd0);
        check("rst_pc_update",     pc_update,          32'd0);
        check("rst_redirect_pc",   redirect_pc,        32'd0);
        check("rst_occupancy",     32'(occupancy),     32'd0);
        check("rst_err_underflow", 32'(err_underflow), 32'd0);
        check("rst_pred_ready",    32'(pred_ready),    32'd0);
`ifdef BRU_STATS_EN
        check("rst_br_count",      br_count,           32'd0);
        check("rst_mispred_count", mispred_count,      32'd0);
`endif
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge: drive one cycle of inputs, check the
    // combinational ready, advance the model, then check registered outputs.
    task automatic step(input logic pv, input logic [31:0] pc, input logic pt,
                        input logic rv, input logic rt, input logic [31:0] tgt);
        logic        exp_ready;
        logic        accept;
        logic [32:0] hd;
        pred_valid = pv;
        pred_pc    = pc;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        res_target = tgt;
        exp_ready  = !m_recover && (exp_q.size() < DEPTH);
        #1;
        check("pred_ready", 32'(pred_ready), 32'(exp_ready));

        accept = pv && exp_ready;
        m_upd  = 1'b0;
        m_mis  = 1'b0;
        if (rv && exp_q.size() == 0) begin
            m_err = 1'b1;
        end else if (rv) begin
            hd     = exp_q.pop_front();
            m_upd  = 1'b1;
            m_pcu  = hd[32:1];
            m_real = rt;
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (rt != hd[0]) begin
                m_mis   = 1'b1;
                m_redir = rt ? tgt : hd[32:1] + 32'(FALLTHRU_OFS);
                exp_q.delete();
                accept  = 1'b0;
                if (m_mp != 32'hFFFF_FFFF) m_mp++;
            end
        end
        if (accept) exp_q.push_back({pc, pt});
        m_recover = m_mis;

        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        pv, pt, rv, rt;
        logic [31:0] pc, tgt;

        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        pred_valid = 1'b0;
        pred_pc    = '0;
        pred_taken = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        res_target = '0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // correctly predicted taken branch
        step(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h800);

        // predicted not-taken, actually taken: redirect to target, one RECOVER bubble
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h400);
        idle();
        idle();

        // predicted taken, actually not-taken: fall-through redirect, younger flushed
        step(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h308, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0);
        idle();
        idle();

        // fill, then push blocked while a correct resolve pops
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'h500 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 32'h0);
        end
        step(1'b1, 32'h5F0, 1'b1, 1'b1, 1'b1, 32'h900);
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h900);
        end

        // resolve on empty queue; a same-cycle push does not satisfy it
        step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h0);
        step(1'b1, 32'h600, 1'b1, 1'b1, 1'b1, 32'h0);
        step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'hA00);
        idle();

        // push + correct resolve in the same cycle keeps occupancy
        step(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h704, 1'b1, 1'b1, 1'b0, 32'h0);
        // push + mispredict in the same cycle drops the push
        step(1'b1, 32'h708, 1'b1, 1'b1, 1'b0, 32'h0);
        idle();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            pv  = ($urandom_range(0, 3) != 0);
            pc  = {$urandom_range(0, 32'hFFFF), 2'b00} | 32'h1000;
            pt  = 1'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 2) == 0);
            tgt = $urandom();
            if (exp_q.size() > 0 && $urandom_range(0, 4) != 0) rt = exp_q[0][0];
            else rt = 1'($urandom_range(0, 1));
            if (n % 97 == 96) pc = 32'hFFFF_FFFC;
            step(pv, pc, pt, rv, rt, tgt);
        end

        // reset mid-operation with entries queued and res_valid high
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'hC00 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 32'h0);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        model_clear();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        res_valid = 1'b0;
        idle();
        step(1'b1, 32'hD00, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks every branch the fetch stage predicted, in program order, and resolves it when the execute stage reports the real outcome. Generates the update port of the 16-way two-level predictor (update_en, pc_update, real_br_taken) and the mispredict redirect to fetch. Sits between IF (prediction push) and EX (resolution). On a mispredict it discards all younger in-flight branches.

## Interface
Parameters:
- DEPTH, 4: in-flight branch entries; power of two, 2..16.
- FALLTHRU_OFS, 4: byte offset added to branch PC for the not-taken redirect.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pred_valid  in  1  IF presents a predicted branch.
- pred_pc  in  32  PC of that branch.
- pred_taken  in  1  predictor output for that branch.
- pred_ready  out  1  entry can be accepted; combinational.
- res_valid  in  1  EX resolves the oldest outstanding branch.
- res_taken  in  1  actual direction.
- res_target  in  32  actual taken target.
- update_en  out  1  one-cycle predictor update strobe.
- pc_update  out  32  PC of the resolved branch.
- real_br_taken  out  1  actual direction to the predictor.
- mispredict  out  1  one-cycle redirect strobe.
- redirect_pc  out  32  correct fetch PC.
- occupancy  out  $clog2(DEPTH+1)  current entry count.
- err_underflow  out  1  sticky; set on a resolution with the queue empty.

## Operation
- Entry: {pc[31:0], pred_taken}, 33 bits. Push when pred_valid && pred_ready.
- Resolve on res_valid with occupancy > 0. Pops the head and compares res_taken with the stored pred_taken.
  - Always: update_en = 1, pc_update = head pc, real_br_taken = res_taken.
  - Mismatch: mispredict = 1. redirect_pc = res_target if res_taken, else head pc + FALLTHRU_OFS (mod 2^32). All remaining entries are cleared. The FSM goes to RECOVER.
- FSM states:
  - RUN: pred_ready = !full.
  - RECOVER: lasts exactly 1 cycle, pred_ready = 0, then returns to RUN.
- Push and resolve in the same cycle:
  - Correct prediction: both happen. Occupancy is unchanged.
  - Mispredict: the pushed entry is dropped as wrong-path, so occupancy becomes 0.
- Full queue: pred_ready = 0 even if a resolve pops in the same cycle. There is no bypass.
- Resolve with an empty queue: no pop and no update/mispredict. err_underflow is set and holds until reset. A same-cycle push does not satisfy that resolve.
- Pointers wrap modulo DEPTH. A full/empty distinction is made with occupancy.

## Timing
- Reset (async assert, synchronous release): pointers, occupancy, all outputs = 0. State = RUN, so pred_ready = 1 after release.
- update_en, pc_update, real_br_taken, mispredict, redirect_pc are registered, valid the cycle after res_valid. Latency is 1.
- Strobes are 0 in every cycle without a valid resolution. Data outputs hold their last value.
- Resolving back-to-back every cycle is supported, except that a mispredict forces the RECOVER bubble on the push side only.
- Reset asserted mid-operation empties the queue immediately and clears the strobes in that cycle.

## Configuration
- BRU_STATS_EN defined: adds output ports br_count[31:0] and mispred_count[31:0].
  - Counted per valid resolution and per mispredict.
  - Saturating at 32'hFFFF_FFFF.
  - Reset to 0.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package bru_pkg:
  - bru_state_t enum {RUN, RECOVER}.
  - bru_entry_t struct {pc, pred_taken}.
  - BRU_PC_W = 32.
- Sub-module bru_fifo: circular buffer of bru_entry_t with push/pop/clear, head output and occupancy. The top level holds the FSM, the compare logic and the output registers.

## Test plan
- Reset, push pc=0x100 taken, resolve taken -> next cycle update_en=1, pc_update=0x100, real_br_taken=1, mispredict=0, occupancy=0.
- Push 0x200 pred not-taken, resolve taken target 0x400 -> mispredict=1, redirect_pc=0x400, following cycle pred_ready=0, then 1.
- Push 0x300 pred taken, 0x304, 0x308; resolve head not-taken -> redirect_pc=0x304, occupancy=0, no updates for 0x304/0x308.
- Fill DEPTH=4 -> pred_ready=0. Same-cycle push and correct resolve -> push rejected, occupancy=3.
- res_valid with empty queue -> no update_en, err_underflow=1 until rst.
- Assert rst with 3 entries and res_valid high -> all outputs 0 immediately, occupancy=0. With BRU_STATS_EN, counters=0.
